// File: rtl/serial_word_assembler.sv
// -----------------------------------------------------------------------------
// serial_word_assembler
//
// Serial-to-parallel front end for an n-bit load register. Framed serial bits
// (sof marks bit 1, sin_valid strobes each bit) are shifted into an internal
// register; when the n-th bit arrives the assembled word is published on
// `word` together with a one-cycle `load` strobe. Framing violations (stray
// bits outside a frame, premature sof) raise a sticky `frame_err`.
//
// Ports:
//   clk        in   rising-edge system clock
//   reset      in   asynchronous, active-high reset
//   sof        in   start-of-frame marker, qualified by sin_valid
//   sin        in   serial data bit, sampled when sin_valid=1
//   sin_valid  in   bit strobe, one bit accepted per edge while high
//   err_clr    in   synchronous clear of frame_err (a same-cycle set wins)
//   word       out  [n-1:0] assembled word, held until the next full frame
//   load       out  one-cycle pulse, word valid in the same cycle
//   busy       out  high while a frame is partially received
//   frame_err  out  sticky framing-error flag
// -----------------------------------------------------------------------------
module serial_word_assembler #(
  parameter int n         = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sof,
  input  logic         sin,
  input  logic         sin_valid,
  input  logic         err_clr,
  output logic [n-1:0] word,
  output logic         load,
  output logic         busy,
  output logic         frame_err
);

  localparam int CNT_W = $clog2(n + 1);
  localparam logic [CNT_W-1:0] N_CNT = CNT_W'(n);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [n-1:0]     shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [n-1:0]     word_q, word_d;
  logic             load_q, load_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             err_set;

  // Shift one bit into the register in the configured direction. Written as
  // per-bit loops so the n=1 case (result is just the new bit) needs no
  // special slicing.
  function automatic logic [n-1:0] shift_in(input logic [n-1:0] cur,
                                            input logic        b);
    logic [n-1:0] r;
    if (MSB_FIRST) begin
      r[0] = b;
      for (int i = 1; i < n; i++) r[i] = cur[i-1];
    end else begin
      r[n-1] = b;
      for (int i = 0; i < n - 1; i++) r[i] = cur[i+1];
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    load_d  = 1'b0;
    err_set = 1'b0;

    unique case (state_q)
      // IDLE and DONE treat sof identically: the bit opens a fresh frame.
      IDLE, DONE: begin
        if (sin_valid && sof) begin
          shreg_d = shift_in('0, sin);
          cnt_d   = CNT_W'(1);
          if (n == 1) begin
            word_d  = shift_in('0, sin);
            load_d  = 1'b1;
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end else if (sin_valid) begin
          // Stray bit outside a frame: dropped, flagged.
          err_set = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = IDLE;
        end
      end

      SHIFT: begin
        if (sin_valid && sof) begin
          // Premature start: abandon the partial frame, restart at bit 1.
          err_set = 1'b1;
          shreg_d = shift_in('0, sin);
          cnt_d   = CNT_W'(1);
        end else if (sin_valid) begin
          shreg_d = shift_in(shreg_q, sin);
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q + CNT_W'(1) == N_CNT) begin
            word_d  = shift_in(shreg_q, sin);
            load_d  = 1'b1;
            state_d = DONE;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d == SHIFT);
    // Set has priority over a simultaneous clear.
    err_d  = err_set | (err_q & ~err_clr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      load_q  <= load_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign word      = word_q;
  assign load      = load_q;
  assign busy      = busy_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_serial_word_assembler.sv
// -----------------------------------------------------------------------------
// tb_serial_word_assembler
//
// Drives two assemblers (MSB-first and LSB-first, n=4) from the same serial
// stimulus. Expected words are queued when a frame is driven; a negedge
// monitor pops and compares them whenever a load pulse appears. Scenario
// tasks add inline checks of busy, frame_err, load count and timing.
// -----------------------------------------------------------------------------
module tb_serial_word_assembler;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         sof = 1'b0;
  logic         sin = 1'b0;
  logic         sin_valid = 1'b0;
  logic         err_clr = 1'b0;

  logic [N-1:0] word_m, word_l;
  logic         load_m, load_l;
  logic         busy_m, busy_l;
  logic         err_m, err_l;

  serial_word_assembler #(.n(N), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset(reset), .sof(sof), .sin(sin), .sin_valid(sin_valid),
    .err_clr(err_clr), .word(word_m), .load(load_m), .busy(busy_m),
    .frame_err(err_m)
  );

  serial_word_assembler #(.n(N), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(reset), .sof(sof), .sin(sin), .sin_valid(sin_valid),
    .err_clr(err_clr), .word(word_l), .load(load_l), .busy(busy_l),
    .frame_err(err_l)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int loads_m = 0;
  int loads_l = 0;
  int last_load_cyc = 0;
  int prev_load_cyc = 0;

  logic [N-1:0] q_m[$];
  logic [N-1:0] q_l[$];

  always @(posedge clk) cyc++;

  // Scoreboard monitor: every load pulse must match the oldest queued word.
  always @(negedge clk) begin
    logic [N-1:0] exp_w;
    if (!reset && load_m) begin
      loads_m++;
      prev_load_cyc = last_load_cyc;
      last_load_cyc = cyc;
      n_cmp++;
      if (q_m.size() == 0) begin
        n_bad++;
        $display("FAIL msb_unexpected_load: word=%b, required no load", word_m);
      end else begin
        exp_w = q_m.pop_front();
        if (word_m !== exp_w) begin
          n_bad++;
          $display("FAIL msb_word: got %b, required %b", word_m, exp_w);
        end
      end
    end
    if (!reset && load_l) begin
      loads_l++;
      n_cmp++;
      if (q_l.size() == 0) begin
        n_bad++;
        $display("FAIL lsb_unexpected_load: word=%b, required no load", word_l);
      end else begin
        exp_w = q_l.pop_front();
        if (word_l !== exp_w) begin
          n_bad++;
          $display("FAIL lsb_word: got %b, required %b", word_l, exp_w);
        end
      end
    end
  end

  // seq[N-1] is sent first. MSB-first expects seq itself; LSB-first places
  // the first bit at word[0], i.e. the bit-reversed sequence.
  function automatic logic [N-1:0] rev(input logic [N-1:0] s);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = s[N-1-i];
    return r;
  endfunction

  task automatic send_bit(input logic s, input logic b);
    sof = s;
    sin = b;
    sin_valid = 1'b1;
    @(posedge clk);
    #1;
    sin_valid = 1'b0;
    sof = 1'b0;
    sin = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_exp(input logic [N-1:0] seq);
    q_m.push_back(seq);
    q_l.push_back(rev(seq));
  endtask

  task automatic test_reset;
    idle(2);
    n_cmp++;
    if ({word_m, load_m, busy_m, err_m} !== 7'd0) begin
      n_bad++;
      $display("FAIL reset_msb: got %b, required 0", {word_m, load_m, busy_m, err_m});
    end
    n_cmp++;
    if ({word_l, load_l, busy_l, err_l} !== 7'd0) begin
      n_bad++;
      $display("FAIL reset_lsb: got %b, required 0", {word_l, load_l, busy_l, err_l});
    end
    reset = 1'b0;
    idle(1);
  endtask

  task automatic test_basic;
    int l0 = loads_m;
    push_exp(4'b1011);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b1);
    n_cmp++;
    if (busy_m !== 1'b1 || load_m !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_midframe: busy=%b load=%b, required busy=1 load=0", busy_m, load_m);
    end
    send_bit(1'b0, 1'b1);
    n_cmp++;
    if (load_m !== 1'b1 || word_m !== 4'b1011 || busy_m !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_done: load=%b word=%b busy=%b, required 1 1011 0", load_m, word_m, busy_m);
    end
    idle(1);
    n_cmp++;
    if (load_m !== 1'b0 || loads_m - l0 != 1 || word_m !== 4'b1011 || err_m !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_after: load=%b pulses=%0d word=%b err=%b, required 0 1 1011 0",
               load_m, loads_m - l0, word_m, err_m);
    end
  endtask

  task automatic test_gapped;
    logic [N-1:0] seq = 4'b1100;
    int l0 = loads_l;
    int gap_bad = 0;
    push_exp(seq);
    for (int i = N - 1; i >= 0; i--) begin
      send_bit(i == N - 1, seq[i]);
      if (i > 0) begin
        for (int g = 0; g < 3; g++) begin
          idle(1);
          if (busy_l !== 1'b1 || load_l !== 1'b0) gap_bad++;
        end
      end
    end
    n_cmp++;
    if (gap_bad != 0) begin
      n_bad++;
      $display("FAIL gapped_busy: %0d gap cycles wrong, required 0", gap_bad);
    end
    n_cmp++;
    if (word_l !== 4'b0011 || load_l !== 1'b1) begin
      n_bad++;
      $display("FAIL gapped_word: word=%b load=%b, required 0011 1", word_l, load_l);
    end
    idle(1);
    n_cmp++;
    if (loads_l - l0 != 1 || busy_l !== 1'b0) begin
      n_bad++;
      $display("FAIL gapped_pulses: pulses=%0d busy=%b, required 1 0", loads_l - l0, busy_l);
    end
  endtask

  task automatic test_premature;
    int l0 = loads_m;
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    push_exp(4'b0110);
    send_bit(1'b1, 1'b0);
    n_cmp++;
    if (err_m !== 1'b1 || err_l !== 1'b1 || busy_m !== 1'b1) begin
      n_bad++;
      $display("FAIL premature_err: err=%b/%b busy=%b, required 1/1 1", err_m, err_l, busy_m);
    end
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b0);
    idle(1);
    n_cmp++;
    if (loads_m - l0 != 1 || word_m !== 4'b0110 || word_l !== 4'b0110) begin
      n_bad++;
      $display("FAIL premature_word: pulses=%0d word=%b/%b, required 1 0110/0110",
               loads_m - l0, word_m, word_l);
    end
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    n_cmp++;
    if (err_m !== 1'b0 || err_l !== 1'b0) begin
      n_bad++;
      $display("FAIL err_clear: err=%b/%b, required 0/0", err_m, err_l);
    end
    // Stray bit and clear in the same cycle: the set must win.
    err_clr = 1'b1;
    send_bit(1'b0, 1'b1);
    err_clr = 1'b0;
    n_cmp++;
    if (err_m !== 1'b1) begin
      n_bad++;
      $display("FAIL set_wins: err=%b, required 1", err_m);
    end
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [N-1:0] a = 4'b1100;
    logic [N-1:0] b = 4'b0101;
    int l0 = loads_m;
    push_exp(a);
    push_exp(b);
    for (int i = N - 1; i >= 0; i--) send_bit(i == N - 1, a[i]);
    n_cmp++;
    if (load_m !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_first_load: load=%b, required 1", load_m);
    end
    for (int i = N - 1; i >= 0; i--) send_bit(i == N - 1, b[i]);
    idle(1);
    n_cmp++;
    if (loads_m - l0 != 2 || last_load_cyc - prev_load_cyc != 4 || err_m !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_timing: pulses=%0d spacing=%0d err=%b, required 2 4 0",
               loads_m - l0, last_load_cyc - prev_load_cyc, err_m);
    end
    idle(5);
    n_cmp++;
    if (word_m !== 4'b0101 || word_l !== 4'b1010) begin
      n_bad++;
      $display("FAIL word_hold: word=%b/%b, required 0101/1010", word_m, word_l);
    end
  endtask

  task automatic test_done_stray;
    logic [N-1:0] s = 4'b0111;
    push_exp(s);
    for (int i = N - 1; i >= 0; i--) send_bit(i == N - 1, s[i]);
    send_bit(1'b0, 1'b1);
    n_cmp++;
    if (err_m !== 1'b1 || busy_m !== 1'b0 || load_m !== 1'b0 || word_m !== 4'b0111) begin
      n_bad++;
      $display("FAIL done_stray: err=%b busy=%b load=%b word=%b, required 1 0 0 0111",
               err_m, busy_m, load_m, word_m);
    end
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
  endtask

  task automatic test_reset_midframe;
    int l0 = loads_m;
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({word_m, load_m, busy_m, err_m} !== 7'd0 || {word_l, load_l, busy_l, err_l} !== 7'd0) begin
      n_bad++;
      $display("FAIL async_reset: msb=%b lsb=%b, required 0 0",
               {word_m, load_m, busy_m, err_m}, {word_l, load_l, busy_l, err_l});
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b0);
    idle(2);
    n_cmp++;
    if (word_m !== 4'd0 || word_l !== 4'd0 || err_m !== 1'b1 || err_l !== 1'b1 ||
        busy_m !== 1'b0 || loads_m != l0) begin
      n_bad++;
      $display("FAIL reset_stray: word=%b/%b err=%b/%b busy=%b pulses=%0d, required 0/0 1/1 0 0",
               word_m, word_l, err_m, err_l, busy_m, loads_m - l0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gapped();
    test_premature();
    test_back_to_back();
    test_done_stray();
    test_reset_midframe();
    n_cmp++;
    if (q_m.size() != 0 || q_l.size() != 0) begin
      n_bad++;
      $display("FAIL missing_loads: %0d/%0d words never loaded, required 0/0",
               q_m.size(), q_l.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_word_assembler.md
Name: serial_word_assembler

Overview:
- Serial-to-parallel front end for the n-bit load register.
- Collects n framed serial bits and presents the assembled word on `word`, together with a one-cycle `load` strobe.
- `word` and `load` connect directly to the downstream register's data and load inputs.
- Detects framing violations and holds a sticky error flag for software or top-level monitoring.

Parameters:
- n, 4, word width in bits (n >= 1). Must match the downstream register width.
- MSB_FIRST, 1, 1 = first received bit lands in word[n-1]; 0 = first received bit lands in word[0].

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- sof  input  1  start-of-frame marker; qualified by sin_valid; marks the first bit of a word.
- sin  input  1  serial data bit; sampled only when sin_valid=1.
- sin_valid  input  1  bit strobe; one bit is accepted per clk edge while high.
- err_clr  input  1  synchronous clear of frame_err.
- word  output  n  assembled parallel word; stable between load pulses.
- load  output  1  one-cycle pulse; word is valid in the same cycle.
- busy  output  1  high while a frame is partially received (state SHIFT).
- frame_err  output  1  sticky framing-error flag.

Behaviour:
- Reset (asynchronous): state=IDLE, shift register=0, bit count=0, word=0, load=0, busy=0, frame_err=0.
- Bit count width is $clog2(n+1).
- Shift direction:
  - MSB_FIRST=1: shreg <= {shreg[n-2:0], sin}.
  - MSB_FIRST=0: shreg <= {sin, shreg[n-1:1]}.
  - n=1: shreg <= sin.
- States: IDLE, SHIFT, DONE. All outputs are registered.
- IDLE:
  - sin_valid & sof: capture bit, count=1, go to SHIFT. If n=1, go straight to DONE instead.
  - sin_valid & !sof: bit discarded, frame_err set (stray bit), stay in IDLE.
- SHIFT:
  - sin_valid & !sof: capture bit, count+1.
  - When count reaches n on this edge: word <= final assembled value, load <= 1, go to DONE.
  - sin_valid & sof (premature start): frame_err set, partial frame discarded, this bit becomes bit 1 of a new frame (count=1), stay in SHIFT.
  - sin_valid=0: hold state; gaps of any length are allowed.
- DONE (exactly one cycle, load=1):
  - sin_valid & sof: accepted as bit 1 of the next frame, go to SHIFT. This gives back-to-back frames with no lost bits.
  - sin_valid & !sof: discarded, frame_err set, go to IDLE.
  - Otherwise: go to IDLE.
- Latency: load is high in the cycle immediately after the edge that samples bit n. word changes only on that same edge.
- word holds its value indefinitely until the next completed frame. Aborted frames never alter word.
- frame_err:
  - Set by any violation above.
  - Cleared by err_clr on the next edge.
  - If set and clear occur in the same cycle, set wins.
- busy=1 exactly while in SHIFT.
- Reset mid-frame: partial data is discarded. The next frame must begin with sof.

Test Plan:
- Reset check: assert reset asynchronously mid-cycle -> word=0, load=0, busy=0, frame_err=0 immediately, without waiting for an edge.
- Basic frame (n=4, MSB_FIRST=1): sin=1,0,1,1 on 4 consecutive strobes, sof with the first bit -> next cycle load=1 for exactly 1 cycle with word=4'b1011, then busy=0.
- Gapped frame (MSB_FIRST=0): bits 1,1,0,0 with 3 idle cycles between strobes -> word=4'b0011, single load pulse, busy high throughout the gaps.
- Premature sof: 2 bits sent, then sof with bits 0,1,1,0 -> frame_err=1, word=4'b0110, one load pulse only. err_clr then -> frame_err=0.
- Back-to-back: frame A=4'b1100 followed immediately by sof of frame B=4'b0101 in the DONE cycle -> two load pulses 4 cycles apart, no error.
- Reset mid-frame and stray bits: reset after 3 bits, then a stray sin_valid without sof -> word stays 0, frame_err=1, no load.
